// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forward-select encodings, register index width,
// and the per-stage destination shadow record.
package cpu_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
   } stage_t;

   // A used, nonzero source that matches a load sitting in EX cannot be forwarded in time.
   function automatic logic load_hit(input logic [REG_AW-1:0] src, input logic use_src,
                                     input stage_t ex);
      return use_src && (src != '0) && ex.v && ex.mr && (ex.rd == src);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forward-select comparator for one operand source against the EX and MEM shadows.
// The EX producer reaches MEM during the consumer's EX cycle, so it wins over MEM.
module fwd_sel
   import cpu_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   input  stage_t            ex,
   input  logic              mem_v,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_rw,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_REG;
      if (use_src && (src != '0)) begin
         // A load in EX has no data yet; that case is a stall, not a forward.
         if (ex.v && ex.rw && !ex.mr && (ex.rd == src)) begin
            sel = FWD_MEM;
         end else if (mem_v && mem_rw && (mem_rd == src)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard unit: shadows EX/MEM destinations, raises load-use stalls,
// applies branch flushes and registers the EX-stage operand forward selects.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_use_rs2_st,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              ex_branch_taken,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic [1:0]        ForwardS,
   output logic              stall,
   output logic              flush_if_id,
   output logic              bubble_ex,
   output logic [CNT_W-1:0]  load_use_cnt
);

   import cpu_pkg::*;

   stage_t             ex_q, ex_d;
   logic               mem_v_q, mem_rw_q;
   logic [REG_AW-1:0]  mem_rd_q;
   logic [1:0]         fwd_a_q, fwd_b_q, fwd_s_q;
   logic [1:0]         sel_a, sel_b, sel_s;
   logic [CNT_W-1:0]   cnt_q;
   logic               load_use;

   always_comb begin
      ex_d    = '0;
      ex_d.v  = id_valid;
      ex_d.rd = id_rd;
      ex_d.rw = id_reg_write;
      ex_d.mr = id_mem_read;
   end

   assign load_use = id_valid &&
                     (load_hit(id_rs1, id_use_rs1, ex_q) ||
                      load_hit(id_rs2, id_use_rs2 | id_use_rs2_st, ex_q));

   // A taken branch makes the ID instruction wrong-path, so its stall is moot.
   assign flush_if_id = ex_branch_taken;
   assign stall       = load_use && !ex_branch_taken;
   assign bubble_ex   = load_use || ex_branch_taken;

   fwd_sel u_sel_a (
      .src     (id_rs1),
      .use_src (id_use_rs1),
      .ex      (ex_q),
      .mem_v   (mem_v_q),
      .mem_rd  (mem_rd_q),
      .mem_rw  (mem_rw_q),
      .sel     (sel_a)
   );

   // ForwardB must stay 00 when the immediate is selected, or it overrides the immediate.
   fwd_sel u_sel_b (
      .src     (id_rs2),
      .use_src (id_use_rs2),
      .ex      (ex_q),
      .mem_v   (mem_v_q),
      .mem_rd  (mem_rd_q),
      .mem_rw  (mem_rw_q),
      .sel     (sel_b)
   );

   fwd_sel u_sel_s (
      .src     (id_rs2),
      .use_src (id_use_rs2_st),
      .ex      (ex_q),
      .mem_v   (mem_v_q),
      .mem_rd  (mem_rd_q),
      .mem_rw  (mem_rw_q),
      .sel     (sel_s)
   );

   // The WB shadow is not kept: nothing forwards from it because the regfile
   // write-before-read covers distance-3 dependencies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q     <= '0;
         mem_v_q  <= 1'b0;
         mem_rd_q <= '0;
         mem_rw_q <= 1'b0;
         fwd_a_q  <= FWD_REG;
         fwd_b_q  <= FWD_REG;
         fwd_s_q  <= FWD_REG;
         cnt_q    <= '0;
      end else if (!hold) begin
         mem_v_q  <= ex_q.v;
         mem_rd_q <= ex_q.rd;
         mem_rw_q <= ex_q.rw;
         if (bubble_ex) begin
            ex_q    <= '0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
            fwd_s_q <= FWD_REG;
         end else begin
            ex_q    <= ex_d;
            fwd_a_q <= sel_a;
            fwd_b_q <= sel_b;
            fwd_s_q <= sel_s;
         end
         cnt_q <= cnt_q + CNT_W'(stall);
      end
   end

   assign ForwardA     = fwd_a_q;
   assign ForwardB     = fwd_b_q;
   assign ForwardS     = fwd_s_q;
   assign load_use_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instruction sequences with hand-computed
// forward selects, stall/flush/bubble levels and stall counter values.
module tb_fwd_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic        hold;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_use_rs2_st;
   logic        id_reg_write, id_mem_read;
   logic        ex_branch_taken;
   logic [1:0]  ForwardA, ForwardB, ForwardS;
   logic        stall, flush_if_id, bubble_ex;
   logic [15:0] load_use_cnt;

   int total;
   int bad;

   fwd_hazard_ctrl #(
      .REG_AW (5),
      .CNT_W  (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .hold            (hold),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rd           (id_rd),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .id_use_rs2_st   (id_use_rs2_st),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .ForwardA        (ForwardA),
      .ForwardB        (ForwardB),
      .ForwardS        (ForwardS),
      .stall           (stall),
      .flush_if_id     (flush_if_id),
      .bubble_ex       (bubble_ex),
      .load_use_cnt    (load_use_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in ID: rd, rs1, rs2, use1, use2, use_st, reg_write, mem_read.
   task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic us,
                        input logic rw, input logic mr);
      id_valid      = 1'b1;
      id_rd         = rd;
      id_rs1        = rs1;
      id_rs2        = rs2;
      id_use_rs1    = u1;
      id_use_rs2    = u2;
      id_use_rs2_st = us;
      id_reg_write  = rw;
      id_mem_read   = mr;
      #1;
   endtask

   task automatic nop();
      id_valid      = 1'b0;
      id_rd         = '0;
      id_rs1        = '0;
      id_rs2        = '0;
      id_use_rs1    = 1'b0;
      id_use_rs2    = 1'b0;
      id_use_rs2_st = 1'b0;
      id_reg_write  = 1'b0;
      id_mem_read   = 1'b0;
      #1;
   endtask

   task automatic drain();
      nop();
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_reset();
      hold = 1'b0;
      ex_branch_taken = 1'b0;
      nop();
      rst_n = 1'b0;
      #12;
      total++; if (ForwardA !== 2'b00) begin bad++; $display("FAIL reset_fa got=%b exp=00", ForwardA); end
      total++; if (ForwardB !== 2'b00) begin bad++; $display("FAIL reset_fb got=%b exp=00", ForwardB); end
      total++; if (ForwardS !== 2'b00) begin bad++; $display("FAIL reset_fs got=%b exp=00", ForwardS); end
      total++; if (load_use_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", load_use_cnt); end
      total++; if ({stall, flush_if_id, bubble_ex} !== 3'b000) begin
         bad++; $display("FAIL reset_ctl got=%b exp=000", {stall, flush_if_id, bubble_ex}); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      drain();
      issue(5'd5, 5'd1, 5'd2, 1, 1, 0, 1, 0);   // add x5,x1,x2
      step();
      issue(5'd6, 5'd5, 5'd7, 1, 1, 0, 1, 0);   // sub x6,x5,x7
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall); end
      step();
      total++; if (ForwardA !== 2'b10) begin bad++; $display("FAIL b2b_fa got=%b exp=10", ForwardA); end
      total++; if (ForwardB !== 2'b00) begin bad++; $display("FAIL b2b_fb got=%b exp=00", ForwardB); end
   endtask

   task automatic test_wb_forward();
      drain();
      issue(5'd5, 5'd1, 5'd2, 1, 1, 0, 1, 0);   // add x5
      step();
      nop();
      step();
      issue(5'd8, 5'd1, 5'd5, 1, 1, 0, 1, 0);   // or x8,x1,x5
      step();
      total++; if (ForwardB !== 2'b01) begin bad++; $display("FAIL wb_fb got=%b exp=01", ForwardB); end
      total++; if (ForwardA !== 2'b00) begin bad++; $display("FAIL wb_fa got=%b exp=00", ForwardA); end
      drain();
      issue(5'd5, 5'd1, 5'd2, 1, 1, 0, 1, 0);   // add x5
      step();
      issue(5'd5, 5'd1, 5'd2, 1, 1, 0, 1, 0);   // add x5 again
      step();
      issue(5'd8, 5'd1, 5'd5, 1, 1, 0, 1, 0);   // or x8,x1,x5
      step();
      total++; if (ForwardB !== 2'b10) begin bad++; $display("FAIL nearest_fb got=%b exp=10", ForwardB); end
   endtask

   task automatic test_load_use();
      drain();
      issue(5'd9, 5'd1, 5'd0, 1, 0, 0, 1, 1);   // lw x9,0(x1)
      step();
      issue(5'd10, 5'd9, 5'd2, 1, 1, 0, 1, 0);  // add x10,x9,x2
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
      total++; if (bubble_ex !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b exp=1", bubble_ex); end
      total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL lu_flush got=%b exp=0", flush_if_id); end
      step();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%b exp=0", stall); end
      total++; if (bubble_ex !== 1'b0) begin bad++; $display("FAIL lu_bubble2 got=%b exp=0", bubble_ex); end
      total++; if (load_use_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", load_use_cnt); end
      total++; if (ForwardA !== 2'b00) begin bad++; $display("FAIL lu_bubble_fa got=%b exp=00", ForwardA); end
      step();
      total++; if (ForwardA !== 2'b01) begin bad++; $display("FAIL lu_fa got=%b exp=01", ForwardA); end
      total++; if (load_use_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=1", load_use_cnt); end
   endtask

   task automatic test_flush();
      drain();
      issue(5'd9, 5'd1, 5'd0, 1, 0, 0, 1, 1);   // lw x9
      step();
      issue(5'd10, 5'd9, 5'd2, 1, 1, 0, 1, 0);  // dependent add, but branch resolves taken
      ex_branch_taken = 1'b1;
      #1;
      total++; if (flush_if_id !== 1'b1) begin bad++; $display("FAIL fl_flush got=%b exp=1", flush_if_id); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b exp=0", stall); end
      total++; if (bubble_ex !== 1'b1) begin bad++; $display("FAIL fl_bubble got=%b exp=1", bubble_ex); end
      step();
      ex_branch_taken = 1'b0;
      nop();
      total++; if (load_use_cnt !== 16'd1) begin bad++; $display("FAIL fl_cnt got=%0d exp=1", load_use_cnt); end
      total++; if (ForwardA !== 2'b00) begin bad++; $display("FAIL fl_fa got=%b exp=00", ForwardA); end
   endtask

   task automatic test_x0_and_imm();
      drain();
      issue(5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0);   // addi x0,x0,1
      step();
      issue(5'd3, 5'd0, 5'd0, 1, 1, 0, 1, 0);   // add x3,x0,x0
      step();
      total++; if ({ForwardA, ForwardB} !== 4'b0000) begin
         bad++; $display("FAIL x0_fwd got=%b exp=0000", {ForwardA, ForwardB}); end
      drain();
      issue(5'd0, 5'd1, 5'd0, 1, 0, 0, 1, 1);   // lw x0
      step();
      issue(5'd3, 5'd0, 5'd0, 1, 1, 0, 1, 0);   // add x3,x0,x0
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", stall); end
      drain();
      issue(5'd4, 5'd1, 5'd2, 1, 1, 0, 1, 0);   // add x4
      step();
      issue(5'd4, 5'd4, 5'd4, 1, 0, 0, 1, 0);   // addi x4,x4,3 (rs2 field aliases x4)
      step();
      total++; if (ForwardA !== 2'b10) begin bad++; $display("FAIL imm_fa got=%b exp=10", ForwardA); end
      total++; if (ForwardB !== 2'b00) begin bad++; $display("FAIL imm_fb got=%b exp=00", ForwardB); end
      issue(5'd0, 5'd1, 5'd4, 1, 0, 1, 0, 0);   // sw x4,0(x1)
      step();
      total++; if (ForwardS !== 2'b10) begin bad++; $display("FAIL st_fs got=%b exp=10", ForwardS); end
      total++; if (ForwardB !== 2'b00) begin bad++; $display("FAIL st_fb got=%b exp=00", ForwardB); end
   endtask

   task automatic test_hold();
      drain();
      issue(5'd5, 5'd1, 5'd2, 1, 1, 0, 1, 0);   // add x5
      step();
      issue(5'd9, 5'd5, 5'd0, 1, 0, 0, 1, 1);   // lw x9,0(x5)
      step();
      total++; if (ForwardA !== 2'b10) begin bad++; $display("FAIL hold_pre_fa got=%b exp=10", ForwardA); end
      issue(5'd10, 5'd9, 5'd2, 1, 1, 0, 1, 0);  // add x10,x9,x2
      hold = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (ForwardA !== 2'b10) begin bad++; $display("FAIL hold_fa[%0d] got=%b exp=10", i, ForwardA); end
         total++; if (load_use_cnt !== 16'd1) begin
            bad++; $display("FAIL hold_cnt[%0d] got=%0d exp=1", i, load_use_cnt); end
         total++; if (stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall); end
      end
      hold = 1'b0;
      step();
      total++; if (load_use_cnt !== 16'd2) begin bad++; $display("FAIL rel_cnt got=%0d exp=2", load_use_cnt); end
      total++; if (ForwardA !== 2'b00) begin bad++; $display("FAIL rel_fa got=%b exp=00", ForwardA); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rel_stall got=%b exp=0", stall); end
      step();
      total++; if (ForwardA !== 2'b01) begin bad++; $display("FAIL rel_fa2 got=%b exp=01", ForwardA); end
   endtask

   task automatic test_reset_mid_stall();
      drain();
      issue(5'd9, 5'd1, 5'd0, 1, 0, 0, 1, 1);   // lw x9
      step();
      issue(5'd10, 5'd9, 5'd2, 1, 1, 0, 1, 0);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({stall, bubble_ex, flush_if_id} !== 3'b000) begin
         bad++; $display("FAIL mid_ctl got=%b exp=000", {stall, bubble_ex, flush_if_id}); end
      total++; if (load_use_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", load_use_cnt); end
      total++; if ({ForwardA, ForwardB, ForwardS} !== 6'b0) begin
         bad++; $display("FAIL mid_fwd got=%b exp=000000", {ForwardA, ForwardB, ForwardS}); end
      step();
      rst_n = 1'b1;
      nop();
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_back_to_back();
      test_wb_forward();
      test_load_use();
      test_flush();
      test_x0_and_imm();
      test_hold();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
